// File: rtl/zeroriscy_trace_buffer.sv
// On-chip instruction trace buffer for zero-riscy: captures retire and late-writeback
// records with timestamps into a circular buffer, with PC trigger and stop/wrap modes.
module zeroriscy_trace_buffer #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TS_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trace_enable,
  input  logic                      clear,
  input  logic                      wrap_mode,
  input  logic                      trig_en,
  input  logic [31:0]               trig_pc,
  input  logic                      ret_valid,
  input  logic [31:0]               ret_pc,
  input  logic [31:0]               ret_instr,
  input  logic                      ret_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] ret_rd_addr,
  input  logic [31:0]               ret_rd_wdata,
  input  logic                      ret_mem_en,
  input  logic [31:0]               ret_mem_addr,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
  input  logic [31:0]               wb_reg_wdata,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_is_wb,
  output logic [TS_WIDTH-1:0]       rd_ts,
  output logic [31:0]               rd_pc,
  output logic [31:0]               rd_instr,
  output logic [31:0]               rd_wdata,
  output logic [31:0]               rd_mem_addr,
  output logic [REG_ADDR_WIDTH-1:0] rd_reg_addr,
  output logic                      rd_reg_we,
  output logic                      rd_mem_en,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      triggered,
  output logic [1:0]                state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FROZEN  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [PW-1:0]             wptr_q, wptr_d;
  logic [PW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic                      triggered_q, triggered_d;
  logic [TS_WIDTH-1:0]       ts_q;

  logic                      hold_vld_q, hold_vld_d;
  logic [REG_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]               hold_data_q, hold_data_d;
  logic [TS_WIDTH-1:0]       hold_ts_q, hold_ts_d;

  logic                      mem_is_wb   [DEPTH];
  logic [TS_WIDTH-1:0]       mem_ts      [DEPTH];
  logic [31:0]               mem_pc      [DEPTH];
  logic [31:0]               mem_instr   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] mem_reg     [DEPTH];
  logic                      mem_we      [DEPTH];
  logic [31:0]               mem_wdata   [DEPTH];
  logic                      mem_men     [DEPTH];
  logic [31:0]               mem_maddr   [DEPTH];

  logic capturing, trig_hit, ret_push, drain, push, full, pop, wr_en;
  logic wb_load, wb_drop;

  logic                      wr_is_wb;
  logic [TS_WIDTH-1:0]       wr_ts;
  logic [31:0]               wr_pc, wr_instr, wr_wdata, wr_maddr;
  logic [REG_ADDR_WIDTH-1:0] wr_reg;
  logic                      wr_we, wr_men;

  assign capturing = trace_enable & ~clear & ((state_q == S_CAPTURE) | (state_q == S_FROZEN));
  assign trig_hit  = trace_enable & ~clear & (state_q == S_ARMED) & ret_valid & (ret_pc == trig_pc);
  assign ret_push  = ret_valid & (capturing | trig_hit);
  // The hold register only drains in CAPTURE so a frozen buffer does not eat writebacks.
  assign drain     = hold_vld_q & trace_enable & ~clear & (state_q == S_CAPTURE) & ~ret_push;
  assign push      = ret_push | drain;
  assign full      = (count_q == CW'(DEPTH));
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid & rd_ready & ~clear;
  assign wr_en     = push & (~full | pop | wrap_mode);
  assign wb_load   = wb_valid & capturing & (~hold_vld_q | drain);
  assign wb_drop   = wb_valid & capturing & hold_vld_q & ~drain;

  always_comb begin
    wr_is_wb = 1'b0;
    wr_ts    = ts_q;
    wr_pc    = ret_pc;
    wr_instr = ret_instr;
    wr_reg   = ret_rd_we ? ret_rd_addr : '0;
    wr_we    = ret_rd_we;
    wr_wdata = ret_rd_wdata;
    wr_men   = ret_mem_en;
    wr_maddr = ret_mem_addr;
    if (!ret_push) begin
      wr_is_wb = 1'b1;
      wr_ts    = hold_ts_q;
      wr_pc    = '0;
      wr_instr = '0;
      wr_reg   = hold_addr_q;
      wr_we    = 1'b1;
      wr_wdata = hold_data_q;
      wr_men   = 1'b0;
      wr_maddr = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_ts_d   = hold_ts_q;

    if (clear) begin
      state_d     = S_IDLE;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      triggered_d = 1'b0;
      hold_vld_d  = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PW'(1);
      // A full wrap-mode push without a pop drops the oldest entry by moving the head.
      if (pop || (wr_en && full)) rptr_d = rptr_q + PW'(1);
      if (wr_en && !full && !pop) count_d = count_q + CW'(1);
      else if (pop && !wr_en)     count_d = count_q - CW'(1);
      if (push && full && !pop) overflow_d = 1'b1;
      if (wb_drop) overflow_d = 1'b1;
      if (trig_hit) triggered_d = 1'b1;

      if (drain) hold_vld_d = 1'b0;
      if (wb_load) begin
        hold_vld_d  = 1'b1;
        hold_addr_d = wb_reg_waddr;
        hold_data_d = wb_reg_wdata;
        hold_ts_d   = ts_q;
      end

      if (!trace_enable) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:    state_d = trig_en ? S_ARMED : S_CAPTURE;
          S_ARMED:   if (trig_hit) state_d = S_CAPTURE;
          S_CAPTURE: state_d = S_CAPTURE;
          S_FROZEN:  if (count_d != CW'(DEPTH)) state_d = S_CAPTURE;
          default:   state_d = S_IDLE;
        endcase
        if (((state_q == S_ARMED) || (state_q == S_CAPTURE)) && wr_en &&
            (count_d == CW'(DEPTH)) && !wrap_mode)
          state_d = S_FROZEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      ts_q        <= '0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_ts_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
      ts_q        <= ts_q + TS_WIDTH'(1);
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_ts_q   <= hold_ts_d;
    end
  end

  // Storage is not reset; occupancy gates every readout.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_is_wb[wptr_q] <= wr_is_wb;
      mem_ts[wptr_q]    <= wr_ts;
      mem_pc[wptr_q]    <= wr_pc;
      mem_instr[wptr_q] <= wr_instr;
      mem_reg[wptr_q]   <= wr_reg;
      mem_we[wptr_q]    <= wr_we;
      mem_wdata[wptr_q] <= wr_wdata;
      mem_men[wptr_q]   <= wr_men;
      mem_maddr[wptr_q] <= wr_maddr;
    end
  end

  assign rd_is_wb    = rd_valid & mem_is_wb[rptr_q];
  assign rd_ts       = rd_valid ? mem_ts[rptr_q]    : '0;
  assign rd_pc       = rd_valid ? mem_pc[rptr_q]    : '0;
  assign rd_instr    = rd_valid ? mem_instr[rptr_q] : '0;
  assign rd_reg_addr = rd_valid ? mem_reg[rptr_q]   : '0;
  assign rd_reg_we   = rd_valid & mem_we[rptr_q];
  assign rd_wdata    = rd_valid ? mem_wdata[rptr_q] : '0;
  assign rd_mem_en   = rd_valid & mem_men[rptr_q];
  assign rd_mem_addr = rd_valid ? mem_maddr[rptr_q] : '0;

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;
  assign state     = state_q;

endmodule

// File: tb/tb_zeroriscy_trace_buffer.sv
// Scoreboard bench for zeroriscy_trace_buffer at DEPTH=4.
module tb_zeroriscy_trace_buffer;

  typedef struct packed {
    logic        is_wb;
    logic [31:0] ts;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  ra;
    logic        we;
    logic [31:0] wdata;
    logic        men;
    logic [31:0] maddr;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_enable = 1'b0, clear = 1'b0, wrap_mode = 1'b0, trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        ret_valid = 1'b0, ret_rd_we = 1'b0, ret_mem_en = 1'b0;
  logic [31:0] ret_pc = '0, ret_instr = '0, ret_rd_wdata = '0, ret_mem_addr = '0;
  logic [4:0]  ret_rd_addr = '0, wb_reg_waddr = '0, rd_reg_addr;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_reg_wdata = '0;
  logic        rd_valid, rd_ready = 1'b0, rd_is_wb, rd_reg_we, rd_mem_en;
  logic [31:0] rd_ts, rd_pc, rd_instr, rd_wdata, rd_mem_addr;
  logic [2:0]  count;
  logic        overflow, triggered;
  logic [1:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] tb_ts;
  rec_t        sb[$];
  rec_t        wb_pend;
  bit          wb_pend_v = 0;

  zeroriscy_trace_buffer #(.DEPTH(4), .TS_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .trace_enable(trace_enable), .clear(clear),
    .wrap_mode(wrap_mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd_we(ret_rd_we), .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
    .ret_mem_en(ret_mem_en), .ret_mem_addr(ret_mem_addr),
    .wb_valid(wb_valid), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_is_wb(rd_is_wb), .rd_ts(rd_ts),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wdata(rd_wdata), .rd_mem_addr(rd_mem_addr),
    .rd_reg_addr(rd_reg_addr), .rd_reg_we(rd_reg_we), .rd_mem_en(rd_mem_en),
    .count(count), .overflow(overflow), .triggered(triggered), .state(state)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value seen during a cycle is what that cycle's record stores.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t head();
    rec_t h;
    h.is_wb = rd_is_wb; h.ts = rd_ts; h.pc = rd_pc; h.instr = rd_instr;
    h.ra = rd_reg_addr; h.we = rd_reg_we; h.wdata = rd_wdata;
    h.men = rd_mem_en; h.maddr = rd_mem_addr;
    return h;
  endfunction

  task automatic drive_ret(input logic [31:0] pc, input logic we, input logic [4:0] ra,
                           input logic men, input bit cap);
    rec_t r;
    ret_valid = 1'b1; ret_pc = pc; ret_instr = {pc[15:0], 16'h0013};
    ret_rd_we = we; ret_rd_addr = ra; ret_rd_wdata = pc + 32'h1000;
    ret_mem_en = men; ret_mem_addr = pc + 32'h8000_0000;
    if (cap) begin
      r.is_wb = 1'b0; r.ts = tb_ts; r.pc = pc; r.instr = {pc[15:0], 16'h0013};
      r.ra = we ? ra : 5'd0; r.we = we; r.wdata = pc + 32'h1000;
      r.men = men; r.maddr = pc + 32'h8000_0000;
      if (sb.size() < 4) sb.push_back(r);
      else if (wrap_mode) begin
        sb.delete(0);
        sb.push_back(r);
      end
    end
  endtask

  task automatic drive_wb(input logic [4:0] ra, input logic [31:0] data);
    wb_valid = 1'b1; wb_reg_waddr = ra; wb_reg_wdata = data;
    if (!wb_pend_v) begin
      wb_pend = '0;
      wb_pend.is_wb = 1'b1; wb_pend.ts = tb_ts; wb_pend.ra = ra;
      wb_pend.we = 1'b1; wb_pend.wdata = data;
      wb_pend_v = 1;
    end
  endtask

  task automatic end_cycle();
    tick();
    ret_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic idle_drain();
    if (wb_pend_v) begin
      sb.push_back(wb_pend);
      wb_pend_v = 0;
    end
    tick();
  endtask

  task automatic retire(input logic [31:0] pc, input logic we, input logic [4:0] ra,
                        input logic men, input bit cap);
    drive_ret(pc, we, ra, men, cap);
    end_cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    wb_pend_v = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({state, count, rd_valid, overflow, triggered} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_status got %h want 00", {state, count, rd_valid, overflow, triggered});
    end
    n_checks++;
    if (head() !== rec_t'(0)) begin
      n_fail++;
      $display("FAIL reset_rd_fields got %h want 0", head());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    rec_t exp;
    trace_enable = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL basic_state got %0d want 2", state); end
    retire(32'h100, 1'b1, 5'd3, 1'b0, 1);
    retire(32'h104, 1'b0, 5'd7, 1'b1, 1);
    retire(32'h108, 1'b1, 5'd9, 1'b1, 1);
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", count); end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL basic_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", rd_valid); end
  endtask

  task automatic test_trigger();
    rec_t exp;
    trace_enable = 1'b0;
    tick();
    trig_en = 1'b1; trig_pc = 32'h200; trace_enable = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL trig_armed got %0d want 1", state); end
    retire(32'h1FC, 1'b1, 5'd1, 1'b0, 0);
    n_checks++;
    if ({state, count, triggered} !== {2'd1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL trig_miss got st=%0d cnt=%0d tr=%b want 1/0/0", state, count, triggered);
    end
    retire(32'h200, 1'b1, 5'd2, 1'b0, 1);
    n_checks++;
    if ({state, triggered} !== {2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL trig_hit got st=%0d tr=%b want 2/1", state, triggered);
    end
    retire(32'h204, 1'b1, 5'd4, 1'b0, 1);
    n_checks++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL trig_count got %0d want 2", count); end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL trig_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    trig_en = 1'b0;
    do_clear();
    n_checks++;
    if ({state, triggered} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL trig_clear got st=%0d tr=%b want 0/0", state, triggered);
    end
  endtask

  task automatic test_stop_full();
    rec_t exp;
    wrap_mode = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) retire(32'h300 + 32'(i * 4), 1'b1, 5'(i + 1), 1'b0, 1);
    n_checks++;
    if ({state, count, overflow} !== {2'd3, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL stop_full got st=%0d cnt=%0d ov=%b want 3/4/1", state, count, overflow);
    end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL stop_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      if (i == 0) begin
        n_checks++;
        if ({state, count} !== {2'd2, 3'd3}) begin
          n_fail++;
          $display("FAIL stop_resume got st=%0d cnt=%0d want 2/3", state, count);
        end
      end
    end
    do_clear();
  endtask

  task automatic test_wrap();
    rec_t exp;
    wrap_mode = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) retire(32'h400 + 32'(i * 4), 1'b1, 5'(i + 8), 1'b1, 1);
    n_checks++;
    if ({state, count, overflow} !== {2'd2, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_status got st=%0d cnt=%0d ov=%b want 2/4/1", state, count, overflow);
    end
    n_checks++;
    if (rd_pc !== 32'h408) begin n_fail++; $display("FAIL wrap_head got %h want 00000408", rd_pc); end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL wrap_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    wrap_mode = 1'b0;
    do_clear();
  endtask

  task automatic test_wb();
    rec_t exp;
    tick();
    drive_ret(32'h500, 1'b1, 5'd6, 1'b1, 1);
    drive_wb(5'd5, 32'hDEAD);
    end_cycle();
    idle_drain();
    n_checks++;
    if ({count, overflow} !== {3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL wb_count got cnt=%0d ov=%b want 2/0", count, overflow);
    end
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL wb_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    rec_t exp;
    drive_ret(32'h600, 1'b1, 5'd10, 1'b0, 1);
    drive_wb(5'd11, 32'h1111);
    end_cycle();
    drive_ret(32'h604, 1'b1, 5'd12, 1'b0, 1);
    drive_wb(5'd13, 32'h2222);
    end_cycle();
    n_checks++;
    if ({count, overflow} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_drop got cnt=%0d ov=%b want 2/1", count, overflow);
    end
    idle_drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (rd_valid !== 1'b1 || head() !== exp) begin
        n_fail++;
        $display("FAIL b2b_pop%0d got v=%b %h want %h", i, rd_valid, head(), exp);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    rd_ready = 1'b1;
    retire(32'h700, 1'b0, 5'd0, 1'b0, 1);
    rd_ready = 1'b0;
    n_checks++;
    if (count !== 3'd1) begin n_fail++; $display("FAIL empty_push_pop got %0d want 1", count); end
    do_clear();
  endtask

  task automatic test_clear();
    tick();
    for (int i = 0; i < 3; i++) retire(32'h800 + 32'(i * 4), 1'b1, 5'd1, 1'b0, 1);
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL clear_pre got %0d want 3", count); end
    do_clear();
    n_checks++;
    if ({state, count, rd_valid, overflow} !== 7'h00) begin
      n_fail++;
      $display("FAIL clear_post got st=%0d cnt=%0d v=%b ov=%b", state, count, rd_valid, overflow);
    end
    tick();
    n_checks++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL clear_rearm got %0d want 2", state); end
    retire(32'h900, 1'b1, 5'd1, 1'b0, 1);
    retire(32'h904, 1'b1, 5'd1, 1'b0, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({state, count, rd_valid} !== 6'h00) begin
      n_fail++;
      $display("FAIL async_reset got st=%0d cnt=%0d v=%b want 0", state, count, rd_valid);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger();
    test_stop_full();
    test_wrap();
    test_wb();
    test_back_to_back();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
